// File: rtl/stack_program_sequencer_pkg.sv
// stack_program_sequencer shared types.
// Opcode values and sequencer state encodings.
package stack_program_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_CPURST = 2'd1,
    SEQ_FETCH  = 2'd2,
    SEQ_EXEC   = 2'd3
  } seq_state_t;

  typedef enum logic [3:0] {
    OP_NOOP = 4'h0,
    OP_PUSH = 4'h1,
    OP_POP  = 4'h2,
    OP_OUTL = 4'h3,
    OP_OUTH = 4'h4,
    OP_SWAP = 4'h5,
    OP_PUSF = 4'h6,
    OP_REPL = 4'h7,
    OP_BINA = 4'h8,
    OP_MULT = 4'h9,
    OP_IDIV = 4'hA,
    OP_CLFL = 4'hB
  } op_t;

endpackage

// File: rtl/stack_program_sequencer_decode.sv
// stack_program_sequencer opcode decoder.
// Maps an opcode to its exec length and operand use.
module seq_op_decode
  import stack_program_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] exec_len,
  output logic       has_operand
);

  // exec cycles after fetch, and whether the next nibble is an operand
  always_comb begin
    exec_len    = 2'd1;
    has_operand = 1'b0;
    case (op_t'(opcode))
      OP_PUSH: begin exec_len = 2'd2; has_operand = 1'b1; end
      OP_POP:  exec_len = 2'd2;
      OP_OUTL: exec_len = 2'd1;
      OP_OUTH: exec_len = 2'd1;
      OP_SWAP: exec_len = 2'd2;
      OP_PUSF: begin exec_len = 2'd2; has_operand = 1'b1; end
      OP_REPL: begin exec_len = 2'd2; has_operand = 1'b1; end
      OP_BINA: begin exec_len = 2'd2; has_operand = 1'b1; end
      OP_MULT: exec_len = 2'd3;
      OP_IDIV: exec_len = 2'd3;
      OP_CLFL: exec_len = 2'd1;
      default: exec_len = 2'd1;
    endcase
  end

endmodule

// File: rtl/stack_program_sequencer.sv
// stack_program_sequencer: nibble program store and replay
// onto stack_cpu inbits with per-opcode timing.
module stack_program_sequencer
  import stack_program_sequencer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter bit LOOP_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [3:0]        load_nibble,
  output logic              load_ready,
  input  logic              start,
  input  logic              abort,
  output logic              cpu_rst,
  output logic [3:0]        cpu_inbits,
  output logic              busy,
  output logic              done,
  output logic              trunc_err,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = ADDR_W + 1;

  logic [3:0] mem [DEPTH];

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  prog_len_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;

  logic [3:0]        opcode;
  logic [3:0]        op_nib;
  logic [1:0]        exec_len;
  logic              has_op;
  logic [CNT_W-1:0]  pc_ext;
  logic [CNT_W-1:0]  next_pc;
  logic              last_op;
  logic [3:0]        operand;
  logic              load_fire;
  logic              start_fire;
  logic              trunc_set;

  seq_op_decode u_dec (
    .opcode      (opcode),
    .exec_len    (exec_len),
    .has_operand (has_op)
  );

  assign opcode  = mem[pc_q];
  assign op_nib  = mem[pc_q + ADDR_W'(1)];
  assign pc_ext  = {1'b0, pc_q};
  assign next_pc = pc_ext + CNT_W'(1) + CNT_W'(has_op);
  assign last_op = (pc_ext + CNT_W'(1)) >= prog_len_q;
  assign operand = (has_op && !last_op) ? op_nib : 4'h0;

  assign load_ready = (state_q == SEQ_IDLE) &&
                      (prog_len_q != CNT_W'(DEPTH));
  assign load_fire  = load_valid && load_ready;
  assign busy       = (state_q != SEQ_IDLE);
  assign pc         = pc_q;

  // program memory write port, contents survive reset
  always_ff @(posedge clk) begin
    if (load_fire)
      mem[prog_len_q[ADDR_W-1:0]] <= load_nibble;
  end

  // state, pc, exec counter and program length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      prog_len_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      if (load_fire)
        prog_len_q <= prog_len_q + CNT_W'(1);
    end
  end

  // sticky truncation flag, cleared by a new load or run
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      trunc_err <= 1'b0;
    else if (load_fire || start_fire)
      trunc_err <= 1'b0;
    else if (trunc_set)
      trunc_err <= 1'b1;
  end

  // next-state and CPU drive
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    cpu_rst    = 1'b0;
    cpu_inbits = 4'h0;
    done       = 1'b0;
    start_fire = 1'b0;
    trunc_set  = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        cpu_rst = 1'b1;
        if (start && (prog_len_q != '0)) begin
          start_fire = 1'b1;
          pc_d       = '0;
          state_d    = SEQ_CPURST;
        end
      end
      SEQ_CPURST: begin
        cpu_rst = 1'b1;
        state_d = SEQ_FETCH;
      end
      SEQ_FETCH: begin
        cpu_inbits = opcode;
        cnt_d      = exec_len - 2'd1;
        trunc_set  = has_op && last_op;
        state_d    = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        cpu_inbits = operand;
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (next_pc >= prog_len_q) begin
          done = 1'b1;
          if (LOOP_EN) begin
            pc_d    = '0;
            state_d = SEQ_FETCH;
          end else begin
            state_d = SEQ_IDLE;
          end
        end else begin
          pc_d    = next_pc[ADDR_W-1:0];
          state_d = SEQ_FETCH;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (abort && (state_q != SEQ_IDLE)) begin
      state_d = SEQ_IDLE;
      done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_program_sequencer.sv
// tb_stack_program_sequencer: directed vector tables
// plus hand sequences for abort, loop and async reset.
module tb_stack_program_sequencer;

  logic       clk;
  logic       rst;
  logic       load_valid, l_load_valid;
  logic [3:0] load_nibble, l_load_nibble;
  logic       load_ready, l_load_ready;
  logic       start, l_start;
  logic       abort, l_abort;
  logic       cpu_rst, l_cpu_rst;
  logic [3:0] cpu_inbits, l_cpu_inbits;
  logic       busy, l_busy;
  logic       done, l_done;
  logic       trunc_err, l_trunc_err;
  logic [3:0] pc, l_pc;

  int checks;
  int failures;

  stack_program_sequencer #(.DEPTH(16), .LOOP_EN(1'b0)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_nibble (load_nibble),
    .load_ready  (load_ready),
    .start       (start),
    .abort       (abort),
    .cpu_rst     (cpu_rst),
    .cpu_inbits  (cpu_inbits),
    .busy        (busy),
    .done        (done),
    .trunc_err   (trunc_err),
    .pc          (pc)
  );

  stack_program_sequencer #(.DEPTH(16), .LOOP_EN(1'b1)) u_loop (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (l_load_valid),
    .load_nibble (l_load_nibble),
    .load_ready  (l_load_ready),
    .start       (l_start),
    .abort       (l_abort),
    .cpu_rst     (l_cpu_rst),
    .cpu_inbits  (l_cpu_inbits),
    .busy        (l_busy),
    .done        (l_done),
    .trunc_err   (l_trunc_err),
    .pc          (l_pc)
  );

  typedef struct packed {
    logic       start;
    logic       rst_o;
    logic [3:0] inb;
    logic       busy;
    logic       done;
    logic       trunc;
    logic [3:0] pc;
  } vec_t;

  vec_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(logic s, logic r, logic [3:0] ib,
                              logic b, logic d, logic t,
                              logic [3:0] p);
    vec_t v;
    v.start = s;
    v.rst_o = r;
    v.inb   = ib;
    v.busy  = b;
    v.done  = d;
    v.trunc = t;
    v.pc    = p;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] n);
    load_valid  = 1'b1;
    load_nibble = n;
    tick();
    load_valid  = 1'b0;
  endtask

  task automatic rst_pulse;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_q(input string name);
    logic [11:0] obs, exp;
    for (int i = 0; i < q.size(); i++) begin
      start = q[i].start;
      tick();
      start = 1'b0;
      obs = {cpu_rst, cpu_inbits, busy, done, trunc_err, pc};
      exp = {q[i].rst_o, q[i].inb, q[i].busy, q[i].done,
             q[i].trunc, q[i].pc};
      chk($sformatf("%s[%0d]", name, i), 32'(obs), 32'(exp));
    end
    q.delete();
  endtask

  initial begin
    int n;
    int dcnt;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    load_valid = 1'b0;  load_nibble = 4'h0;
    start = 1'b0;       abort = 1'b0;
    l_load_valid = 1'b0; l_load_nibble = 4'h0;
    l_start = 1'b0;     l_abort = 1'b0;

    #12;
    chk("reset_outs",
        32'({cpu_rst, cpu_inbits, busy, done, trunc_err, pc}),
        32'({1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0}));
    chk("reset_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // start with an empty program does nothing
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start", 32'(busy), 32'd0);

    // basic program with operand hold
    load(4'h1); load(4'h5); load(4'h3);
    q.push_back(mk(1, 1, 4'h0, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h1, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h5, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h5, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h3, 1, 0, 0, 4'd2));
    q.push_back(mk(0, 0, 4'h0, 1, 1, 0, 4'd2));
    q.push_back(mk(0, 1, 4'h0, 0, 0, 0, 4'd2));
    run_q("basic");

    // truncated PUSH as last nibble, then rerun clears flag
    rst_pulse();
    load(4'h2); load(4'h1);
    q.push_back(mk(1, 1, 4'h0, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h2, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h1, 1, 0, 0, 4'd1));
    q.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'd1));
    q.push_back(mk(0, 0, 4'h0, 1, 1, 1, 4'd1));
    q.push_back(mk(0, 1, 4'h0, 0, 0, 1, 4'd1));
    q.push_back(mk(1, 1, 4'h0, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h2, 1, 0, 0, 4'd0));
    run_q("trunc");
    tick(); tick(); tick(); tick(); tick(); tick();

    // MULT takes three exec cycles
    rst_pulse();
    load(4'h1); load(4'h7); load(4'h1);
    load(4'h3); load(4'h9); load(4'h3);
    q.push_back(mk(1, 1, 4'h0, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h1, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h7, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h7, 1, 0, 0, 4'd0));
    q.push_back(mk(0, 0, 4'h1, 1, 0, 0, 4'd2));
    q.push_back(mk(0, 0, 4'h3, 1, 0, 0, 4'd2));
    q.push_back(mk(0, 0, 4'h3, 1, 0, 0, 4'd2));
    q.push_back(mk(0, 0, 4'h9, 1, 0, 0, 4'd4));
    q.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'd4));
    q.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'd4));
    q.push_back(mk(0, 0, 4'h0, 1, 0, 0, 4'd4));
    q.push_back(mk(0, 0, 4'h3, 1, 0, 0, 4'd5));
    q.push_back(mk(0, 0, 4'h0, 1, 1, 0, 4'd5));
    q.push_back(mk(0, 1, 4'h0, 0, 0, 0, 4'd5));
    run_q("mult");

    // full memory: 17th nibble dropped, PUSH at pc 15 truncates
    rst_pulse();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill_ready[%0d]", i), 32'(load_ready), 32'd1);
      load(i == 15 ? 4'h1 : 4'hB);
    end
    chk("full_ready", 32'(load_ready), 32'd0);
    load(4'h1);
    chk("drop_ready", 32'(load_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("full_busy_ready", 32'(load_ready), 32'd0);
    n = 1;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("full_done_cycle", 32'(n), 32'd34);
    chk("full_last_pc", 32'(pc), 32'd15);
    chk("full_trunc", 32'(trunc_err), 32'd1);
    tick();
    chk("full_idle", 32'(busy), 32'd0);

    // abort beats instruction end
    rst_pulse();
    load(4'h3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_abort_done", 32'(done), 32'd1);
    abort = 1'b1;
    #1;
    chk("abort_no_done", 32'(done), 32'd0);
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'({busy, cpu_rst}), 32'b01);

    // loop mode: done every two cycles
    l_load_valid  = 1'b1;
    l_load_nibble = 4'h3;
    tick();
    l_load_valid  = 1'b0;
    l_start = 1'b1;
    tick();
    l_start = 1'b0;
    chk("loop_cpurst", 32'(l_cpu_rst), 32'd1);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (l_done) dcnt++;
    end
    chk("loop_dones", 32'(dcnt), 32'd5);
    chk("loop_norst", 32'({l_busy, l_cpu_rst}), 32'b10);
    l_abort = 1'b1;
    tick();
    l_abort = 1'b0;
    chk("loop_abort", 32'(l_busy), 32'd0);

    // async reset mid-EXEC
    l_start = 1'b1;
    tick();
    l_start = 1'b0;
    tick();
    tick();
    chk("loop_in_exec", 32'({l_busy, l_done}), 32'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst",
        32'({l_cpu_rst, l_busy, l_done, l_cpu_inbits}),
        32'({1'b1, 1'b0, 1'b0, 4'h0}));
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_len0", 32'(l_load_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
